// File: rtl/game_session_controller.sv
// Play-session sequencer: IDLE -> countdown -> timed play (pausable) -> over, with saturating score and slice/miss sound arbiter.
// Start/pause act 3 edges after the pin; sound_valid rises 2 cycles after an event and holds valid/id stable until sound_ready.
module game_session_controller #(
  parameter int TICK_CYCLES = 65_000_000,
  parameter int COUNTDOWN_S = 3,
  parameter int GAME_S      = 120
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        start_in,
  input  logic        pause_in,
  input  logic        slice_in,
  input  logic        miss_in,
  input  logic        sound_ready_in,
  output logic        sound_valid_out,
  output logic [1:0]  sound_id_out,
  output logic        run_out,
  output logic        start_music_out,
  output logic        stop_music_out,
  output logic [2:0]  state_out,
  output logic [7:0]  seconds_left_out,
  output logic [11:0] score_out
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAYING   = 3'd2,
    S_PAUSED    = 3'd3,
    S_OVER      = 3'd4
  } state_t;

  state_t          state, state_nxt;
  logic [7:0]      secs, secs_nxt;
  logic [11:0]     score;
  logic [CW-1:0]   cnt;
  logic            start_s1, start_s2, start_q;
  logic            pause_s1, pause_s2;
  logic            start_evt, tick, cnt_clr, cnt_run, score_clr;
  logic            start_music_nxt, stop_music_nxt;
  logic            slice_evt, miss_evt, load, grant_slice, grant_miss;
  logic            pend_slice, pend_miss;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      start_s1 <= 1'b0;
      start_s2 <= 1'b0;
      start_q  <= 1'b0;
      pause_s1 <= 1'b0;
      pause_s2 <= 1'b0;
    end else begin
      start_s1 <= start_in;
      start_s2 <= start_s1;
      start_q  <= start_s2;
      pause_s1 <= pause_in;
      pause_s2 <= pause_s1;
    end
  end

  assign start_evt = start_s2 && !start_q;
  assign tick      = (cnt == TICK_LAST);

  // A pause landing on a tick freezes the count at TICK_LAST so the tick fires on resume.
  assign cnt_run = (state == S_COUNTDOWN) ||
                   ((state == S_PLAYING) && !(pause_s2 && tick));

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_run) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    state_nxt       = state;
    secs_nxt        = secs;
    start_music_nxt = 1'b0;
    stop_music_nxt  = 1'b0;
    cnt_clr         = 1'b0;
    score_clr       = 1'b0;
    case (state)
      S_IDLE, S_OVER: begin
        if (start_evt) begin
          state_nxt = S_COUNTDOWN;
          secs_nxt  = 8'(COUNTDOWN_S);
          cnt_clr   = 1'b1;
          score_clr = 1'b1;
        end
      end
      S_COUNTDOWN: begin
        if (tick) begin
          if (secs > 8'd1) begin
            secs_nxt = secs - 8'd1;
          end else begin
            state_nxt       = S_PLAYING;
            secs_nxt        = 8'(GAME_S);
            start_music_nxt = 1'b1;
            cnt_clr         = 1'b1;
          end
        end
      end
      S_PLAYING: begin
        if (pause_s2) begin
          state_nxt = S_PAUSED;
        end else if (tick) begin
          if (secs > 8'd1) begin
            secs_nxt = secs - 8'd1;
          end else begin
            state_nxt      = S_OVER;
            secs_nxt       = 8'd0;
            stop_music_nxt = 1'b1;
          end
        end
      end
      S_PAUSED: begin
        if (!pause_s2) state_nxt = S_PLAYING;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state           <= S_IDLE;
      secs            <= 8'd0;
      start_music_out <= 1'b0;
      stop_music_out  <= 1'b0;
    end else begin
      state           <= state_nxt;
      secs            <= secs_nxt;
      start_music_out <= start_music_nxt;
      stop_music_out  <= stop_music_nxt;
    end
  end

  assign slice_evt = slice_in && (state == S_PLAYING);
  assign miss_evt  = miss_in && (state == S_PLAYING);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      score <= 12'd0;
    end else if (score_clr) begin
      score <= 12'd0;
    end else if (slice_evt && (score != 12'hFFF)) begin
      score <= score + 12'd1;
    end
  end

  // Output register reloads whenever it is empty or being accepted; slice wins over miss.
  assign load        = !sound_valid_out || sound_ready_in;
  assign grant_slice = load && pend_slice;
  assign grant_miss  = load && !pend_slice && pend_miss;

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      pend_slice      <= 1'b0;
      pend_miss       <= 1'b0;
      sound_valid_out <= 1'b0;
      sound_id_out    <= 2'd0;
    end else begin
      pend_slice <= slice_evt || (pend_slice && !grant_slice);
      pend_miss  <= miss_evt || (pend_miss && !grant_miss);
      if (load) begin
        sound_valid_out <= pend_slice || pend_miss;
        sound_id_out    <= pend_slice ? 2'd1 : (pend_miss ? 2'd2 : 2'd0);
      end
    end
  end

  assign run_out          = (state == S_PLAYING);
  assign state_out        = state;
  assign seconds_left_out = secs;
  assign score_out        = score;

endmodule

// File: tb/tb_game_session_controller.sv
// Bench for game_session_controller: directed segment table, random sessions against an elapsed-time model,
// async reset checks and score saturation on a long-game instance.
module tb_game_session_controller;
  localparam int T  = 4;
  localparam int CD = 3;
  localparam int G  = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, pause, slice, miss, ready;
  logic        sound_valid, run, start_music, stop_music;
  logic [1:0]  sound_id;
  logic [2:0]  state;
  logic [7:0]  secs;
  logic [11:0] score;

  game_session_controller #(.TICK_CYCLES(T), .COUNTDOWN_S(CD), .GAME_S(G)) dut (
    .clk_in(clk), .rst_in(rst_n), .start_in(start), .pause_in(pause),
    .slice_in(slice), .miss_in(miss), .sound_ready_in(ready),
    .sound_valid_out(sound_valid), .sound_id_out(sound_id), .run_out(run),
    .start_music_out(start_music), .stop_music_out(stop_music),
    .state_out(state), .seconds_left_out(secs), .score_out(score)
  );

  logic        s_start, s_slice;
  logic        s_valid, s_run, s_smus, s_pmus;
  logic [1:0]  s_id;
  logic [2:0]  s_state;
  logic [7:0]  s_secs;
  logic [11:0] s_score;

  game_session_controller #(.TICK_CYCLES(20), .COUNTDOWN_S(1), .GAME_S(255)) dut_sat (
    .clk_in(clk), .rst_in(rst_n), .start_in(s_start), .pause_in(1'b0),
    .slice_in(s_slice), .miss_in(1'b0), .sound_ready_in(1'b1),
    .sound_valid_out(s_valid), .sound_id_out(s_id), .run_out(s_run),
    .start_music_out(s_smus), .stop_music_out(s_pmus),
    .state_out(s_state), .seconds_left_out(s_secs), .score_out(s_score)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase plus active cycles elapsed in that phase; seconds derive from elapsed time.
  int m_st, m_el, m_sc, m_v, m_id;
  bit m_ps, m_pm, m_sm, m_stm;
  bit hs[3];
  bit hp[3];

  task automatic model_reset();
    m_st = 0; m_el = 0; m_sc = 0; m_v = 0; m_id = 0;
    m_ps = 0; m_pm = 0; m_sm = 0; m_stm = 0;
    for (int i = 0; i < 3; i++) begin hs[i] = 0; hp[i] = 0; end
  endtask

  function automatic int m_secs();
    case (m_st)
      1:       return CD - m_el / T;
      2, 3:    return G - m_el / T;
      default: return 0;
    endcase
  endfunction

  task automatic model_edge();
    bit evt, pz, fire;
    int st0;
    evt = hs[1] && !hs[2];
    pz  = hp[1];
    st0 = m_st;
    m_sm = 0; m_stm = 0;
    case (st0)
      0, 4: if (evt) begin m_st = 1; m_el = 0; m_sc = 0; end
      1: begin
        m_el++;
        if (m_el == CD * T) begin m_st = 2; m_el = 0; m_sm = 1; end
      end
      2: begin
        if (pz) begin
          if ((m_el + 1) % T != 0) m_el++;
          m_st = 3;
        end else begin
          m_el++;
          if (m_el == G * T) begin m_st = 4; m_stm = 1; end
        end
      end
      3: if (!pz) m_st = 2;
      default: ;
    endcase
    if (st0 == 2 && slice && m_sc < 4095) m_sc++;
    fire = !m_v || ready;
    if (fire) begin
      if (m_ps) begin m_v = 1; m_id = 1; m_ps = 0; end
      else if (m_pm) begin m_v = 1; m_id = 2; m_pm = 0; end
      else begin m_v = 0; m_id = 0; end
    end
    if (st0 == 2 && slice) m_ps = 1;
    if (st0 == 2 && miss) m_pm = 1;
    hs[2] = hs[1]; hs[1] = hs[0]; hs[0] = start;
    hp[2] = hp[1]; hp[1] = hp[0]; hp[0] = pause;
  endtask

  task automatic check_all();
    chk("state", state, m_st);
    chk("seconds_left", secs, m_secs());
    chk("score", score, m_sc);
    chk("sound_valid", sound_valid, m_v);
    if (m_v != 0) chk("sound_id", sound_id, m_id);
    chk("run", run, (m_st == 2) ? 1 : 0);
    chk("start_music", start_music, m_sm);
    chk("stop_music", stop_music, m_stm);
  endtask

  task automatic step(input bit s, input bit p, input bit sl, input bit mi, input bit rd);
    start = s; pause = p; slice = sl; miss = mi; ready = rd;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_state"}, state, 0);
    chk({tag, "_secs"}, secs, 0);
    chk({tag, "_score"}, score, 0);
    chk({tag, "_valid"}, sound_valid, 0);
    chk({tag, "_id"}, sound_id, 0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_smus"}, start_music, 0);
    chk({tag, "_pmus"}, stop_music, 0);
  endtask

  typedef struct {
    bit s, p, sl, mi, rd;
    int n;
    int st, sec, sc, v, id;
  } seg_t;

  seg_t tbl[$];

  initial begin
    bit rs, rp;
    int k;
    start = 0; pause = 0; slice = 0; miss = 0; ready = 0;
    s_start = 0; s_slice = 0;
    rst_n = 1;
    model_reset();
    #2 rst_n = 0;
    #1 chk_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    check_all();

    //               s  p  sl mi rd  n   st sec sc v id
    tbl.push_back('{1, 0, 0, 0, 1, 2,  0, 0, 0, 0, 0}); // synchronizer filling
    tbl.push_back('{1, 0, 0, 0, 1, 1,  1, 3, 0, 0, 0}); // 3rd edge: countdown
    tbl.push_back('{0, 0, 0, 0, 1, 4,  1, 2, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 4,  1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 3,  1, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1,  2, 5, 0, 0, 0}); // 12 cycles of countdown
    tbl.push_back('{0, 0, 1, 0, 1, 5,  2, 4, 5, 1, 1}); // 5 slices
    tbl.push_back('{0, 0, 0, 0, 1, 14, 2, 1, 5, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1,  4, 0, 5, 0, 0}); // 20 play cycles
    tbl.push_back('{0, 0, 1, 0, 1, 3,  4, 0, 5, 0, 0}); // slices in OVER ignored
    tbl.push_back('{1, 0, 0, 0, 1, 3,  1, 3, 0, 0, 0}); // restart clears score
    tbl.push_back('{1, 0, 0, 0, 1, 12, 2, 5, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 4,  2, 4, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 2,  2, 4, 0, 0, 0});
    tbl.push_back('{0, 1, 0, 0, 1, 1,  3, 4, 0, 0, 0}); // paused
    tbl.push_back('{0, 1, 1, 0, 1, 47, 3, 4, 0, 0, 0}); // slices while paused ignored
    tbl.push_back('{0, 0, 0, 0, 1, 2,  3, 4, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1,  2, 4, 0, 0, 0}); // resumed
    tbl.push_back('{0, 0, 0, 0, 1, 12, 2, 1, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 1,  4, 0, 0, 0, 0}); // still 20 active cycles
    tbl.push_back('{1, 0, 0, 0, 1, 3,  1, 3, 0, 0, 0});
    tbl.push_back('{0, 0, 0, 0, 1, 12, 2, 5, 0, 0, 0});
    tbl.push_back('{0, 0, 1, 1, 0, 1,  2, 5, 1, 0, 0}); // slice+miss, not ready
    tbl.push_back('{0, 0, 0, 0, 0, 11, 2, 2, 1, 1, 1}); // slice held stable
    tbl.push_back('{0, 0, 0, 0, 1, 1,  2, 2, 1, 1, 2}); // miss follows
    tbl.push_back('{0, 0, 0, 0, 1, 1,  2, 2, 1, 0, 0});
    tbl.push_back('{0, 0, 1, 0, 0, 2,  2, 1, 3, 1, 1}); // request in flight

    foreach (tbl[i]) begin
      for (int j = 0; j < tbl[i].n; j++)
        step(tbl[i].s, tbl[i].p, tbl[i].sl, tbl[i].mi, tbl[i].rd);
      chk($sformatf("seg%0d_state", i), state, tbl[i].st);
      chk($sformatf("seg%0d_secs", i), secs, tbl[i].sec);
      chk($sformatf("seg%0d_score", i), score, tbl[i].sc);
      chk($sformatf("seg%0d_valid", i), sound_valid, tbl[i].v);
      if (tbl[i].v != 0) chk($sformatf("seg%0d_id", i), sound_id, tbl[i].id);
    end

    // Asynchronous reset mid-play with a sound outstanding, checked before any clock edge.
    #2 rst_n = 0;
    #1 chk_all_zero("midreset");
    model_reset();
    start = 0; pause = 0; slice = 0; miss = 0; ready = 0;
    @(negedge clk);
    rst_n = 1;
    check_all();

    rs = 0; rp = 0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) rs = !rs;
      if ($urandom_range(0, 39) == 0) rp = !rp;
      step(rs, rp, $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1);
    end

    start = 0; pause = 0; slice = 0; miss = 0; ready = 1;
    s_start = 1;
    k = 0;
    while (s_state != 3'd2 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("sat_reach_play", s_state, 2);
    s_slice = 1;
    repeat (4094) @(negedge clk);
    chk("sat_score_4094", s_score, 4094);
    repeat (3) @(negedge clk);
    chk("sat_score_4095", s_score, 4095);
    s_slice = 0;
    @(negedge clk);
    chk("sat_score_hold", s_score, 4095);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
